// File: rtl/ctrl_sequencer_if.sv
// Memory handshake between the control sequencer (master) and main memory (slave).
interface ctrl_sequencer_if #(
    parameter int IR_W = 16
);
    logic            mem_req;
    logic            mem_we;
    logic [IR_W-1:0] mem_rdata;
    logic            mem_ack;

    modport master (output mem_req, output mem_we, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_rdata, output mem_ack);
endinterface

// File: rtl/ctrl_sequencer.sv
// mARC sequential control unit: state/IR registers, memory handshake, bus-timeout trap.
// Optional retired-instruction counter enabled by defining CTRL_SEQ_RETIRE_CNT_EN.
module ctrl_sequencer #(
    parameter int RA_W  = 3,
    parameter int IR_W  = 16,
    parameter int TMO_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          status,
    input  logic                trap_clr,
    ctrl_sequencer_if.master    mem,
    output logic [3*RA_W+8:0]   ctrlword,
    output logic [IR_W-1:0]     ir,
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    output logic [31:0]         retired,
`endif
    output logic                trap
);
    localparam logic [RA_W-1:0]  PC_ADDR  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2**TMO_W) - 2);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_INCPC, S_ALU, S_ALUI, S_MEM, S_BRANCH, S_TRAP
    } state_t;

    typedef struct packed {
        logic [RA_W-1:0] a;
        logic [RA_W-1:0] b;
        logic [RA_W-1:0] d;
        logic            rw_reg;
        logic            bsel_imm;
        logic            dsel_mem;
        logic            wr_psr;
        logic            disp;
        logic [3:0]      op;
    } cw_t;

    state_t           state;
    logic [TMO_W-1:0] tmo;
    cw_t              cw;
    logic             req, we, taken;

    logic [1:0]      cls;
    logic [3:0]      op;
    logic            cc;
    logic [RA_W-1:0] rd, rs1, rs2;
    logic            n_f, z_f, v_f;

    assign cls = ir[IR_W-1:IR_W-2];
    assign op  = ir[3*RA_W+4:3*RA_W+1];
    assign cc  = ir[3*RA_W];
    assign rd  = ir[3*RA_W-1:2*RA_W];
    assign rs1 = ir[2*RA_W-1:RA_W];
    assign rs2 = ir[RA_W-1:0];
    assign n_f = status[3];
    assign z_f = status[2];
    assign v_f = status[1];

    // Carry is not consulted by any branch condition.
    logic unused;
    assign unused = status[0];

    always_comb begin
        taken = 1'b0;
        unique case (rd[2:0])
            3'b000: taken = 1'b1;
            3'b001: taken = z_f;
            3'b010: taken = ~z_f;
            3'b011: taken = ~z_f & ~(n_f ^ v_f);
            3'b100: taken = z_f | (n_f ^ v_f);
            3'b101: taken = ~(n_f ^ v_f);
            3'b110: taken = n_f ^ v_f;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        cw  = '0;
        req = 1'b0;
        we  = 1'b0;
        unique case (state)
            S_FETCH: begin
                cw.a = PC_ADDR;
                req  = 1'b1;
            end
            S_INCPC: begin
                cw.a      = PC_ADDR;
                cw.d      = PC_ADDR;
                cw.rw_reg = 1'b1;
                cw.op     = 4'b1100;
            end
            S_ALU, S_ALUI: begin
                cw.a        = rs1;
                cw.b        = (state == S_ALUI) ? '0 : rs2;
                cw.d        = rd;
                cw.rw_reg   = 1'b1;
                cw.bsel_imm = (state == S_ALUI);
                cw.wr_psr   = cc;
                cw.op       = op;
            end
            S_MEM: begin
                cw.a = rs1;
                cw.b = rs2;
                req  = 1'b1;
                we   = op[0];
                if (!op[0]) begin
                    // Load data lands in rd only in the cycle memory delivers it.
                    cw.d        = rd;
                    cw.dsel_mem = 1'b1;
                    cw.rw_reg   = mem.mem_ack;
                end
            end
            S_BRANCH: begin
                if (taken) begin
                    cw.a      = PC_ADDR;
                    cw.d      = PC_ADDR;
                    cw.disp   = 1'b1;
                    cw.rw_reg = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ctrlword    = cw;
    assign mem.mem_req = req;
    assign mem.mem_we  = we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RESET;
            ir    <= '0;
            tmo   <= '0;
            trap  <= 1'b0;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
            retired <= '0;
`endif
        end else begin
            tmo <= '0;
            unique case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH, S_MEM: begin
                    // Ack wins over the terminal count in the same cycle.
                    if (mem.mem_ack) begin
                        if (state == S_FETCH) begin
                            ir    <= mem.mem_rdata;
                            state <= S_INCPC;
                        end else begin
                            state <= S_FETCH;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
                            retired <= retired + 32'd1;
`endif
                        end
                    end else if (tmo == TMO_LAST) begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_INCPC: begin
                    unique case (cls)
                        2'b00:   state <= S_ALU;
                        2'b01:   state <= S_ALUI;
                        2'b10:   state <= S_MEM;
                        default: state <= S_BRANCH;
                    endcase
                end
                S_ALU, S_ALUI, S_BRANCH: begin
                    state <= S_FETCH;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
                    retired <= retired + 32'd1;
`endif
                end
                S_TRAP: begin
                    if (trap_clr) begin
                        trap  <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end
endmodule
